fetch_unit: RTL and testbench

Front end of the single-issue core. Owns the architectural fetch PC and issues in-order word fetches to instruction memory over a valid/ready request channel. Buffers returned instructions with their PCs for decode. Consumes the redirect target produced by the next-PC select logic on taken jumps and branches, and discards wrong-path fetches.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch front end.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    output fetch_entry_t               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Flush wins over push/pop; a pop seen by the consumer this cycle still completes.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credited imem requests and
// buffers returned instructions with their PCs, dropping wrong-path returns.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst_pc,
    output logic [INST_W-1:0] inst_data
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = CW + 2;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] outstanding, occupancy;
    logic [SW-1:0] in_use;
    logic          credit_ok, req_fire, dropping;
    logic          rsp_take, rsp_drop, rsp_counted;
    logic          pcq_full, pcq_empty, buf_full, buf_empty;
    fetch_entry_t  pcq_in, pcq_head, buf_in, buf_head;

    // The in-flight PC queue holds exactly the non-stale requests, so its count is "outstanding".
    assign in_use         = SW'(outstanding) + SW'(drop_cnt_q) + SW'(occupancy);
    assign credit_ok      = (in_use < SW'(BUF_DEPTH)) && !pcq_full && !buf_full;
    assign imem_req_valid = rst_n && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dropping    = (state_q == FLUSH);
    assign rsp_drop    = imem_rsp_valid && dropping;
    assign rsp_take    = imem_rsp_valid && !dropping && !pcq_empty;
    assign rsp_counted = rsp_drop || rsp_take;

    assign pcq_in = '{pc: fetch_pc_q, inst: '0};

    always_comb begin
        buf_in      = pcq_head;
        buf_in.inst = imem_rsp_data;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) drop_cnt_d = drop_cnt_q + outstanding - CW'(rsp_counted);
        else if (rsp_drop)  drop_cnt_d = drop_cnt_q - CW'(1);

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc & ~XLEN'(3);
        else if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            case (state_q)
                RUN:     if (redirect_valid && drop_cnt_d != '0) state_q <= FLUSH;
                FLUSH:   if (drop_cnt_d == '0) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pcq (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .data_i  (pcq_in),
        .pop_i   (rsp_take),
        .data_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (outstanding)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rsp_take),
        .data_i  (buf_in),
        .pop_i   (inst_valid && inst_ready),
        .data_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (occupancy)
    );

    assign inst_valid = !buf_empty;
    assign inst_pc    = inst_valid ? buf_head.pc   : '0;
    assign inst_data  = inst_valid ? buf_head.inst : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with BUF_DEPTH=2 and a 1-cycle imem model.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    int          checks = 0;
    int          failures = 0;
    logic        auto_rsp;
    logic [31:0] req_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    always #5 clk = ~clk;

    // One cycle: log handshakes mid-cycle, step the clock, then play the imem (data = ~addr).
    task automatic tick();
        logic        f;
        logic [31:0] a;
        #1;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        if (f) req_log.push_back(a);
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid = f;
            imem_rsp_data  = ~a;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;
        auto_rsp       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete();
        got_pc.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_inst_data: got %h expected 0", inst_data); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL stream_first_req: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL stream_second_req: got v=%b a=%h expected v=1 a=4", imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stream_first_inst: got v=%b pc=%h d=%h expected v=1 pc=0 d=ffffffff", inst_valid, inst_pc, inst_data); end
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_pc.size() <= i || got_pc[i] !== 32'(4 * i) || got_data[i] !== ~32'(4 * i)) begin
                failures++; $display("FAIL stream_inst[%0d]: got %0d entries, expected pc=%h data=%h", i, got_pc.size(), 32'(4 * i), ~32'(4 * i));
            end
            checks++;
            if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
                failures++; $display("FAIL stream_req[%0d]: got %0d entries, expected addr=%h", i, req_log.size(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b0;
        repeat (5) tick();
        #1;
        checks++; if (req_log.size() != 2) begin failures++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_stalled: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_pc.size() <= i || got_pc[i] !== 32'(4 * i)) begin
                failures++; $display("FAIL bp_order[%0d]: got %0d entries, expected pc=%h", i, got_pc.size(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        auto_rsp   = 1'b0;
        inst_ready = 1'b0;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = ~32'h0;
        tick();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rd_withdraw: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rd_flushed: got %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL rd_target_req: got v=%b a=%h expected v=1 a=100", imem_req_valid, imem_req_addr); end
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = ~32'h4;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rd_drop_credit: got %b expected 0", imem_req_valid); end
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = ~32'h100;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rd_stale_dropped: got %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin failures++; $display("FAIL rd_after_drop_req: got v=%b a=%h expected v=1 a=104", imem_req_valid, imem_req_addr); end
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== ~32'h100) begin failures++; $display("FAIL rd_first_inst: got v=%b pc=%h d=%h expected v=1 pc=100 d=fffffeff", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_withdraw: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL mis_addr: got v=%b a=%h expected v=1 a=200", imem_req_valid, imem_req_addr); end
        repeat (6) tick();
        checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h200 || got_data[0] !== ~32'h200) begin failures++; $display("FAIL mis_inst: got %0d entries, expected pc=200", got_pc.size()); end
    endtask

    task automatic test_redirect_rsp_handshake();
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        #1;
        checks++; if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL rh_setup: got rsp=%b v=%b pc=%h expected rsp=1 v=1 pc=0", imem_rsp_valid, inst_valid, inst_pc); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL rh_after: got v=%b rv=%b a=%h expected v=0 rv=1 a=300", inst_valid, imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h304) begin failures++; $display("FAIL rh_no_drop: got v=%b a=%h expected v=1 a=304", imem_req_valid, imem_req_addr); end
        repeat (6) tick();
        checks++; if (got_pc.size() < 3 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h300 || got_pc[2] !== 32'h304) begin failures++; $display("FAIL rh_sequence: got %0d entries, expected pcs 0,300,304", got_pc.size()); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        auto_rsp   = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rf_two_outstanding: got %b expected 0", imem_req_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rf_two_drops: got %b expected 0", imem_req_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL rf_async_clear: got rv=%b v=%b pc=%h d=%h a=%h expected all 0", imem_req_valid, inst_valid, inst_pc, inst_data, imem_req_addr); end
        do_reset();
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL rf_restart: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got v=%b a=%h expected v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
        tick();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero: got v=%b a=%h expected v=1 a=0", imem_req_valid, imem_req_addr); end
        repeat (6) tick();
        checks++; if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0) begin failures++; $display("FAIL wrap_insts: got %0d entries, expected pcs fffffffc,0", got_pc.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_misaligned();
        test_redirect_rsp_handshake();
        test_reset_in_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
